// File: rtl/pulse_count_ctrl_pkg.sv
// Shared state encoding and default sizing for the pulse counter controller.
package pulse_count_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/pulse_count_ctrl_if.sv
// Tick inputs, configuration and status bundle between debouncers, controller and display.
interface pulse_count_ctrl_if
    import pulse_count_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) ();

    logic             start_tick;
    logic             clr_tick;
    logic             pulse_tick;
    logic             dir;
    logic [WIDTH-1:0] limit;
    logic [WIDTH-1:0] q;
    logic             running;
    logic             done;
    logic             wrap;

    modport master (
        output start_tick, clr_tick, pulse_tick, dir, limit,
        input  q, running, done, wrap
    );

    modport slave (
        input  start_tick, clr_tick, pulse_tick, dir, limit,
        output q, running, done, wrap
    );

endinterface

// File: rtl/pulse_count_ctrl_updown_limit_cnt.sv
// Up/down counter that wraps between 0 and a limit; load has priority over counting.
module pulse_count_ctrl_updown_limit_cnt
    import pulse_count_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             dir,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] q,
    output logic             at_term
);

    // Terminal is checked before stepping, so the count never passes the limit.
    assign at_term = dir ? (q == '0) : (q == limit);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            if (at_term) begin
                q <= dir ? limit : '0;
            end else if (dir) begin
                q <= q - 1'b1;
            end else begin
                q <= q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/pulse_count_ctrl.sv
// Start/pause/clear sequencing around an up/down limit counter, with registered status.
module pulse_count_ctrl
    import pulse_count_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter bit AUTO_RELOAD = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    pulse_count_ctrl_if.slave bus
);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] limit_r;
    logic             dir_r;
    logic [WIDTH-1:0] limit_eff;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             at_term;
    logic             cnt_en;
    logic             cnt_load;
    logic             cfg_load;
    logic             wrap_next;
    logic             running_r;
    logic             done_r;
    logic             wrap_r;

    assign limit_eff = (bus.limit == '0) ? '1 : bus.limit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            limit_r   <= '1;
            dir_r     <= 1'b0;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            wrap_r    <= 1'b0;
        end else begin
            state     <= state_next;
            running_r <= (state_next == ST_RUN);
            done_r    <= (state_next == ST_DONE);
            wrap_r    <= wrap_next;
            if (cfg_load) begin
                limit_r <= limit_eff;
                dir_r   <= bus.dir;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_en     = 1'b0;
        cnt_load   = 1'b0;
        cfg_load   = 1'b0;
        load_val   = '0;
        wrap_next  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start_tick) begin
                    state_next = ST_RUN;
                    cfg_load   = 1'b1;
                    cnt_load   = 1'b1;
                    load_val   = bus.dir ? limit_eff : '0;
                end
            end
            ST_RUN: begin
                if (bus.start_tick) begin
                    state_next = ST_HOLD;
                end
                // A pulse arriving with start is still counted; reaching DONE overrides HOLD.
                if (bus.pulse_tick) begin
                    if (!at_term) begin
                        cnt_en = 1'b1;
                    end else if (AUTO_RELOAD) begin
                        cnt_en    = 1'b1;
                        wrap_next = 1'b1;
                    end else begin
                        state_next = ST_DONE;
                    end
                end
            end
            ST_HOLD: begin
                if (bus.start_tick) begin
                    state_next = ST_RUN;
                end
            end
            default: begin
            end
        endcase

        if (bus.clr_tick) begin
            state_next = ST_IDLE;
            cnt_en     = 1'b0;
            cnt_load   = 1'b1;
            cfg_load   = 1'b0;
            load_val   = '0;
            wrap_next  = 1'b0;
        end
    end

    pulse_count_ctrl_updown_limit_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .en       (cnt_en),
        .dir      (dir_r),
        .load     (cnt_load),
        .load_val (load_val),
        .limit    (limit_r),
        .q        (q),
        .at_term  (at_term)
    );

    assign bus.q       = q;
    assign bus.running = running_r;
    assign bus.done    = done_r;
    assign bus.wrap    = wrap_r;

endmodule

// File: tb/tb_pulse_count_ctrl.sv
// Drives auto-reload and stop-at-limit instances with identical ticks and checks both against a model.
module tb_pulse_count_ctrl;

    localparam int W    = 8;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_tick;
    logic         clr_tick;
    logic         pulse_tick;
    logic         dir;
    logic [W-1:0] limit;

    pulse_count_ctrl_if #(.WIDTH(W)) ifa ();
    pulse_count_ctrl_if #(.WIDTH(W)) ifn ();

    assign ifa.start_tick = start_tick;
    assign ifa.clr_tick   = clr_tick;
    assign ifa.pulse_tick = pulse_tick;
    assign ifa.dir        = dir;
    assign ifa.limit      = limit;
    assign ifn.start_tick = start_tick;
    assign ifn.clr_tick   = clr_tick;
    assign ifn.pulse_tick = pulse_tick;
    assign ifn.dir        = dir;
    assign ifn.limit      = limit;

    pulse_count_ctrl #(.WIDTH(W), .AUTO_RELOAD(1'b1)) dut_ar (
        .clk   (clk),
        .reset (reset),
        .bus   (ifa)
    );

    pulse_count_ctrl #(.WIDTH(W), .AUTO_RELOAD(1'b0)) dut_nr (
        .clk   (clk),
        .reset (reset),
        .bus   (ifn)
    );

    always #5 clk = ~clk;

    // mode: 0 idle, 1 counting, 2 paused, 3 finished
    typedef struct {
        int mode;
        int cnt;
        int lim;
        bit down;
        bit wrap;
    } model_t;

    typedef struct {
        bit st;
        bit pu;
        int eq;
        bit erun;
        bit ewrap;
    } vec_t;

    int     total = 0;
    int     bad   = 0;
    model_t ma;
    model_t mn;
    vec_t   tbl[8];

    function automatic model_t step(model_t m, bit ar, bit rs, bit st, bit cl, bit pu, bit d, int lim);
        model_t n = m;
        n.wrap = 1'b0;
        if (rs) begin
            n.mode = 0; n.cnt = 0; n.lim = MAXV; n.down = 1'b0;
            return n;
        end
        if (cl) begin
            n.mode = 0; n.cnt = 0;
            return n;
        end
        case (m.mode)
            0: if (st) begin
                n.mode = 1;
                n.lim  = (lim == 0) ? MAXV : lim;
                n.down = d;
                n.cnt  = d ? n.lim : 0;
            end
            1: begin
                if (st) n.mode = 2;
                if (pu) begin
                    if (!m.down && m.cnt < m.lim)  n.cnt = m.cnt + 1;
                    else if (m.down && m.cnt > 0)  n.cnt = m.cnt - 1;
                    else if (ar) begin
                        n.cnt  = m.down ? m.lim : 0;
                        n.wrap = 1'b1;
                    end else n.mode = 3;
                end
            end
            2: if (st) n.mode = 1;
            default: ;
        endcase
        return n;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("ar_q",    int'(ifa.q),       ma.cnt);
        chk("ar_run",  int'(ifa.running), int'(ma.mode == 1));
        chk("ar_done", int'(ifa.done),    int'(ma.mode == 3));
        chk("ar_wrap", int'(ifa.wrap),    int'(ma.wrap));
        chk("nr_q",    int'(ifn.q),       mn.cnt);
        chk("nr_run",  int'(ifn.running), int'(mn.mode == 1));
        chk("nr_done", int'(ifn.done),    int'(mn.mode == 3));
        chk("nr_wrap", int'(ifn.wrap),    int'(mn.wrap));
    endtask

    task automatic cycle(input bit rs, input bit st, input bit cl, input bit pu, input bit d, input int lim);
        reset      = rs;
        start_tick = st;
        clr_tick   = cl;
        pulse_tick = pu;
        dir        = d;
        limit      = lim[W-1:0];
        @(posedge clk);
        ma = step(ma, 1'b1, rs, st, cl, pu, d, lim);
        mn = step(mn, 1'b0, rs, st, cl, pu, d, lim);
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic pulses(input int n, input bit d, input int lim);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, d, lim);
    endtask

    initial begin
        tbl[0] = '{st: 1'b1, pu: 1'b0, eq: 0, erun: 1'b1, ewrap: 1'b0};
        tbl[1] = '{st: 1'b0, pu: 1'b1, eq: 1, erun: 1'b1, ewrap: 1'b0};
        tbl[2] = '{st: 1'b0, pu: 1'b1, eq: 2, erun: 1'b1, ewrap: 1'b0};
        tbl[3] = '{st: 1'b0, pu: 1'b1, eq: 3, erun: 1'b1, ewrap: 1'b0};
        tbl[4] = '{st: 1'b0, pu: 1'b1, eq: 4, erun: 1'b1, ewrap: 1'b0};
        tbl[5] = '{st: 1'b0, pu: 1'b1, eq: 5, erun: 1'b1, ewrap: 1'b0};
        tbl[6] = '{st: 1'b0, pu: 1'b1, eq: 0, erun: 1'b1, ewrap: 1'b1};
        tbl[7] = '{st: 1'b0, pu: 1'b1, eq: 1, erun: 1'b1, ewrap: 1'b0};

        reset = 1'b1; start_tick = 1'b0; clr_tick = 1'b0; pulse_tick = 1'b0;
        dir = 1'b0; limit = '0;
        @(negedge clk);
        cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
        cycle(1'b1, 1'b1, 1'b0, 1, 1, 7);
        chk("reset_q",    int'(ifa.q), 0);
        chk("reset_run",  int'(ifa.running), 0);
        chk("reset_done", int'(ifn.done), 0);

        // up count to 5 with wrap
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, tbl[i].st, 1'b0, tbl[i].pu, 1'b0, 5);
            chk("t1_q",    int'(ifa.q),       tbl[i].eq);
            chk("t1_run",  int'(ifa.running), int'(tbl[i].erun));
            chk("t1_wrap", int'(ifa.wrap),    int'(tbl[i].ewrap));
        end
        chk("t1_nr_done", int'(ifn.done), 1);
        chk("t1_nr_q",    int'(ifn.q),    5);

        // down count to 0, stop in DONE
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 3);
        chk("t2_load", int'(ifn.q), 3);
        pulses(4, 1'b1, 3);
        chk("t2_done",   int'(ifn.done), 1);
        chk("t2_q",      int'(ifn.q),    0);
        chk("t2_ar_q",   int'(ifa.q),    3);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 3);
        chk("t2_ign_q",    int'(ifn.q),    0);
        chk("t2_ign_done", int'(ifn.done), 1);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3);
        chk("t2_clr_done", int'(ifn.done), 0);

        // pause/resume, limit changes while paused are ignored
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        pulses(2, 1'b0, 10);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10);
        chk("t3_hold_run", int'(ifa.running), 0);
        pulses(3, 1'b0, 1);
        chk("t3_hold_q", int'(ifa.q), 2);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        pulses(1, 1'b0, 1);
        chk("t3_resume_q",  int'(ifa.q), 3);
        chk("t3_resume_nq", int'(ifn.q), 3);

        // start with pulse in RUN, then clr with everything
        pulses(1, 1'b0, 1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1);
        chk("t4_q",   int'(ifa.q),       5);
        chk("t4_run", int'(ifa.running), 0);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1);
        chk("t4_clr_q", int'(ifn.q), 0);

        // limit 0 means full range
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0);
        pulses(MAXV, 1'b0, 0);
        chk("t5_max_q", int'(ifa.q), MAXV);
        pulses(1, 1'b0, 0);
        chk("t5_wrap_q",  int'(ifa.q),    0);
        chk("t5_wrap",    int'(ifa.wrap), 1);
        chk("t5_nr_done", int'(ifn.done), 1);
        chk("t5_nr_q",    int'(ifn.q),    MAXV);

        // reset mid-run together with a pulse
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 20);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 20);
        pulses(7, 1'b0, 20);
        chk("t6_q7", int'(ifa.q), 7);
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 20);
        chk("t6_q",   int'(ifa.q),       0);
        chk("t6_run", int'(ifa.running), 0);

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 99) == 0,
                  $urandom_range(0, 9) == 0,
                  $urandom_range(0, 39) == 0,
                  1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 12)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
